// File: rtl/traffic_lite_rr_if.sv
// Lamp/sensor bundle for traffic_lite_rr.
//   car        : per-approach car sensors (driven by master)
//   green      : one-hot green lamps
//   yellow     : one-hot yellow lamps
//   active_dir : index of the approach owning green/yellow
//   phase      : 00 GREEN, 01 YELLOW, 10 ALL_RED
interface traffic_lite_rr_if #(
   parameter int unsigned NUM_DIR = 2
);
   localparam int unsigned AW = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

   logic [NUM_DIR-1:0] car;
   logic [NUM_DIR-1:0] green;
   logic [NUM_DIR-1:0] yellow;
   logic [AW-1:0]      active_dir;
   logic [1:0]         phase;

   // Environment side: drives sensors, watches lamps.
   modport master (
      output car,
      input  green, yellow, active_dir, phase
   );

   // Controller side.
   modport slave (
      input  car,
      output green, yellow, active_dir, phase
   );
endinterface

// File: rtl/traffic_lite_rr.sv
// Round-robin traffic light controller for NUM_DIR approaches.
// Cycles GREEN -> YELLOW -> ALL_RED -> GREEN, handing green to the next
// requesting approach in round-robin order. All lamp outputs are registered.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (approach 0 green)
//   bus   : traffic_lite_rr_if.slave (car in; green, yellow, active_dir, phase out)
module traffic_lite_rr #(
   parameter int unsigned NUM_DIR      = 2,
   parameter int unsigned MIN_GREEN    = 8,
   parameter int unsigned MAX_GREEN    = 32,
   parameter int unsigned YELLOW_TIME  = 4,
   parameter int unsigned ALL_RED_TIME = 2,
   parameter int unsigned CNT_W        = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   traffic_lite_rr_if.slave        bus
);

   localparam int unsigned AW = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

   localparam logic [1:0] ST_GREEN   = 2'b00;
   localparam logic [1:0] ST_YELLOW  = 2'b01;
   localparam logic [1:0] ST_ALL_RED = 2'b10;

   localparam logic [CNT_W-1:0] MIN_GREEN_M1 = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAX_GREEN_M1 = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] YELLOW_M1    = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] ALL_RED_M1   = CNT_W'(ALL_RED_TIME - 1);

   logic [1:0]         state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [AW-1:0]      active_q, active_d;
   logic [AW-1:0]      next_q,   next_d;
   logic [NUM_DIR-1:0] green_q,  green_d;
   logic [NUM_DIR-1:0] yellow_q, yellow_d;
   logic [1:0]         phase_q,  phase_d;

   logic [NUM_DIR-1:0] req_c;
   logic               rr_found_c;
   logic [AW-1:0]      rr_sel_c;
   int unsigned        rr_idx;

   // The active approach never requests itself.
   assign req_c = bus.car & ~(NUM_DIR'(1) << active_q);

   // Round-robin pick: first requester at distance 1, 2, ... from active_q.
   always_comb begin
      rr_found_c = 1'b0;
      rr_sel_c   = active_q;
      rr_idx     = 0;
      for (int unsigned k = 1; k < NUM_DIR; k++) begin
         rr_idx = 32'(active_q) + k;
         if (rr_idx >= NUM_DIR) rr_idx = rr_idx - NUM_DIR;
         if (!rr_found_c && req_c[AW'(rr_idx)]) begin
            rr_found_c = 1'b1;
            rr_sel_c   = AW'(rr_idx);
         end
      end
   end

   // Next-state, counter and lamp decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      active_d = active_q;
      next_d   = next_q;

      case (state_q)
         ST_GREEN: begin
            // MAX_GREEN term is already implied by MIN_GREEN <= MAX_GREEN;
            // kept so the bound is explicit.
            if (rr_found_c && (cnt_q >= MIN_GREEN_M1 || cnt_q >= MAX_GREEN_M1)) begin
               state_d = ST_YELLOW;
               next_d  = rr_sel_c;
               cnt_d   = '0;
            end
         end
         ST_YELLOW: begin
            if (cnt_q >= YELLOW_M1) begin
               state_d = ST_ALL_RED;
               cnt_d   = '0;
            end
         end
         ST_ALL_RED: begin
            if (cnt_q >= ALL_RED_M1) begin
               state_d  = ST_GREEN;
               active_d = next_q;
               cnt_d    = '0;
            end
         end
         default: begin
            state_d = ST_GREEN;
            cnt_d   = '0;
         end
      endcase

      green_d  = (state_d == ST_GREEN)  ? (NUM_DIR'(1) << active_d) : '0;
      yellow_d = (state_d == ST_YELLOW) ? (NUM_DIR'(1) << active_d) : '0;
      phase_d  = state_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_GREEN;
         cnt_q    <= '0;
         active_q <= '0;
         next_q   <= '0;
         green_q  <= NUM_DIR'(1);
         yellow_q <= '0;
         phase_q  <= ST_GREEN;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         next_q   <= next_d;
         green_q  <= green_d;
         yellow_q <= yellow_d;
         phase_q  <= phase_d;
      end
   end

   assign bus.green      = green_q;
   assign bus.yellow     = yellow_q;
   assign bus.active_dir = active_q;
   assign bus.phase      = phase_q;

endmodule

// File: tb/tb_traffic_lite_rr.sv
// Directed bench for traffic_lite_rr: a 2-approach instance (dut_a) and a
// 4-approach instance (dut_b), both with default timing parameters.
module tb_traffic_lite_rr;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   traffic_lite_rr_if #(.NUM_DIR(2)) bus_a ();
   traffic_lite_rr_if #(.NUM_DIR(4)) bus_b ();

   traffic_lite_rr #(.NUM_DIR(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   traffic_lite_rr #(.NUM_DIR(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns at the negedge where rst_n is released; outputs there are cycle 0.
   task automatic apply_reset(input logic [1:0] ca, input logic [3:0] cb);
      @(negedge clk);
      rst_n     = 1'b0;
      bus_a.car = ca;
      bus_b.car = cb;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      bus_a.car = 2'b10;
      bus_b.car = 4'b1110;
      repeat (3) @(negedge clk);
      n_checks++; if (bus_a.green !== 2'b01) begin n_fail++; $display("FAIL reset_green_a got %b exp 01", bus_a.green); end
      n_checks++; if (bus_a.yellow !== 2'b00) begin n_fail++; $display("FAIL reset_yellow_a got %b exp 00", bus_a.yellow); end
      n_checks++; if (bus_a.phase !== 2'b00) begin n_fail++; $display("FAIL reset_phase_a got %b exp 00", bus_a.phase); end
      n_checks++; if (bus_a.active_dir !== 1'b0) begin n_fail++; $display("FAIL reset_active_a got %0d exp 0", bus_a.active_dir); end
      n_checks++; if (bus_b.green !== 4'b0001) begin n_fail++; $display("FAIL reset_green_b got %b exp 0001", bus_b.green); end
      n_checks++; if (bus_b.active_dir !== 2'd0) begin n_fail++; $display("FAIL reset_active_b got %0d exp 0", bus_b.active_dir); end
   endtask

   // No requests (own car bit set) -> green held on approach 0.
   task automatic test_idle_hold();
      apply_reset(2'b01, 4'b0001);
      for (int i = 0; i < 100; i++) begin
         if (i > 0) @(negedge clk);
         n_checks++; if (bus_a.green !== 2'b01) begin n_fail++; $display("FAIL idle_green_a cyc %0d got %b exp 01", i, bus_a.green); end
         n_checks++; if (bus_a.yellow !== 2'b00) begin n_fail++; $display("FAIL idle_yellow_a cyc %0d got %b exp 00", i, bus_a.yellow); end
         n_checks++; if (bus_a.phase !== 2'b00) begin n_fail++; $display("FAIL idle_phase_a cyc %0d got %b exp 00", i, bus_a.phase); end
         n_checks++; if (bus_b.green !== 4'b0001) begin n_fail++; $display("FAIL idle_green_b cyc %0d got %b exp 0001", i, bus_b.green); end
      end
   endtask

   // Held request: 8 green, 4 yellow, 2 all-red, then green on approach 1.
   task automatic test_basic_change();
      logic [1:0] eg, ey, ep;
      logic [3:0] egb, eyb;
      apply_reset(2'b10, 4'b0010);
      for (int i = 0; i < 15; i++) begin
         if (i > 0) @(negedge clk);
         eg  = (i < 8) ? 2'b01 : (i >= 14) ? 2'b10 : 2'b00;
         ey  = (i >= 8 && i < 12) ? 2'b01 : 2'b00;
         ep  = (i < 8) ? 2'd0 : (i < 12) ? 2'd1 : (i < 14) ? 2'd2 : 2'd0;
         egb = (i < 8) ? 4'b0001 : (i >= 14) ? 4'b0010 : 4'b0000;
         eyb = (i >= 8 && i < 12) ? 4'b0001 : 4'b0000;
         n_checks++; if (bus_a.green !== eg) begin n_fail++; $display("FAIL basic_green_a cyc %0d got %b exp %b", i, bus_a.green, eg); end
         n_checks++; if (bus_a.yellow !== ey) begin n_fail++; $display("FAIL basic_yellow_a cyc %0d got %b exp %b", i, bus_a.yellow, ey); end
         n_checks++; if (bus_a.phase !== ep) begin n_fail++; $display("FAIL basic_phase_a cyc %0d got %b exp %b", i, bus_a.phase, ep); end
         n_checks++; if (bus_b.green !== egb) begin n_fail++; $display("FAIL basic_green_b cyc %0d got %b exp %b", i, bus_b.green, egb); end
         n_checks++; if (bus_b.yellow !== eyb) begin n_fail++; $display("FAIL basic_yellow_b cyc %0d got %b exp %b", i, bus_b.yellow, eyb); end
      end
      n_checks++; if (bus_a.active_dir !== 1'b1) begin n_fail++; $display("FAIL basic_active_a got %0d exp 1", bus_a.active_dir); end
      n_checks++; if (bus_b.active_dir !== 2'd1) begin n_fail++; $display("FAIL basic_active_b got %0d exp 1", bus_b.active_dir); end
   endtask

   // Active on NUM_DIR-1 with request on 0 wraps to 0.
   task automatic test_wraparound();
      apply_reset(2'b10, 4'b0000);
      repeat (14) @(negedge clk);
      n_checks++; if (bus_a.active_dir !== 1'b1) begin n_fail++; $display("FAIL wrap_start_a got %0d exp 1", bus_a.active_dir); end
      bus_a.car = 2'b01;
      repeat (13) @(negedge clk);
      n_checks++; if (bus_a.phase !== 2'd2) begin n_fail++; $display("FAIL wrap_allred_phase got %b exp 10", bus_a.phase); end
      n_checks++; if ((bus_a.green | bus_a.yellow) !== 2'b00) begin n_fail++; $display("FAIL wrap_allred_lamps got %b exp 00", bus_a.green | bus_a.yellow); end
      @(negedge clk);
      n_checks++; if (bus_a.green !== 2'b01) begin n_fail++; $display("FAIL wrap_green_a got %b exp 01", bus_a.green); end
      n_checks++; if (bus_a.active_dir !== 1'b0) begin n_fail++; $display("FAIL wrap_active_a got %0d exp 0", bus_a.active_dir); end
      n_checks++; if (bus_b.green !== 4'b0001) begin n_fail++; $display("FAIL wrap_idle_b got %b exp 0001", bus_b.green); end
   endtask

   // 4 approaches, active 1, car=1101 held -> 2, 3, 0.
   task automatic test_round_robin4();
      logic [1:0] exp_dir [3];
      logic [1:0] prev;
      logic [3:0] oh;
      exp_dir[0] = 2'd2; exp_dir[1] = 2'd3; exp_dir[2] = 2'd0;
      apply_reset(2'b00, 4'b0010);
      repeat (14) @(negedge clk);
      n_checks++; if (bus_b.active_dir !== 2'd1) begin n_fail++; $display("FAIL rr_start_b got %0d exp 1", bus_b.active_dir); end
      bus_b.car = 4'b1101;
      prev = 2'd1;
      for (int r = 0; r < 3; r++) begin
         repeat (8) @(negedge clk);
         oh = 4'b0001 << prev;
         n_checks++; if (bus_b.yellow !== oh) begin n_fail++; $display("FAIL rr_yellow round %0d got %b exp %b", r, bus_b.yellow, oh); end
         repeat (6) @(negedge clk);
         oh = 4'b0001 << exp_dir[r];
         n_checks++; if (bus_b.active_dir !== exp_dir[r]) begin n_fail++; $display("FAIL rr_active round %0d got %0d exp %0d", r, bus_b.active_dir, exp_dir[r]); end
         n_checks++; if (bus_b.green !== oh) begin n_fail++; $display("FAIL rr_green round %0d got %b exp %b", r, bus_b.green, oh); end
         prev = exp_dir[r];
      end
      n_checks++; if (bus_a.green !== 2'b01) begin n_fail++; $display("FAIL rr_idle_a got %b exp 01", bus_a.green); end
   endtask

   // One-cycle request at cnt=10 still completes the change.
   task automatic test_withdrawal();
      apply_reset(2'b00, 4'b0000);
      repeat (10) @(negedge clk);
      n_checks++; if (bus_a.green !== 2'b01) begin n_fail++; $display("FAIL wd_hold_a got %b exp 01", bus_a.green); end
      bus_a.car = 2'b10;
      @(negedge clk);
      bus_a.car = 2'b00;
      n_checks++; if (bus_a.yellow !== 2'b01) begin n_fail++; $display("FAIL wd_yellow_a got %b exp 01", bus_a.yellow); end
      repeat (3) @(negedge clk);
      n_checks++; if (bus_a.phase !== 2'd1) begin n_fail++; $display("FAIL wd_yellow_end got %b exp 01", bus_a.phase); end
      @(negedge clk);
      n_checks++; if (bus_a.phase !== 2'd2) begin n_fail++; $display("FAIL wd_allred_a got %b exp 10", bus_a.phase); end
      n_checks++; if ((bus_a.green | bus_a.yellow) !== 2'b00) begin n_fail++; $display("FAIL wd_allred_lamps got %b exp 00", bus_a.green | bus_a.yellow); end
      repeat (2) @(negedge clk);
      n_checks++; if (bus_a.green !== 2'b10) begin n_fail++; $display("FAIL wd_green_a got %b exp 10", bus_a.green); end
      n_checks++; if (bus_a.active_dir !== 1'b1) begin n_fail++; $display("FAIL wd_active_a got %0d exp 1", bus_a.active_dir); end
   endtask

   // Async reset mid-yellow abandons the change; MIN_GREEN restarts.
   task automatic test_reset_mid_yellow();
      apply_reset(2'b10, 4'b0000);
      repeat (9) @(negedge clk);
      n_checks++; if (bus_a.yellow !== 2'b01) begin n_fail++; $display("FAIL ry_pre_yellow got %b exp 01", bus_a.yellow); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bus_a.green !== 2'b01) begin n_fail++; $display("FAIL ry_async_green got %b exp 01", bus_a.green); end
      n_checks++; if (bus_a.yellow !== 2'b00) begin n_fail++; $display("FAIL ry_async_yellow got %b exp 00", bus_a.yellow); end
      n_checks++; if (bus_a.phase !== 2'b00) begin n_fail++; $display("FAIL ry_async_phase got %b exp 00", bus_a.phase); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         if (i < 8) begin
            n_checks++; if (bus_a.green !== 2'b01) begin n_fail++; $display("FAIL ry_regreen cyc %0d got %b exp 01", i, bus_a.green); end
         end else begin
            n_checks++; if (bus_a.yellow !== 2'b01) begin n_fail++; $display("FAIL ry_yellow cyc %0d got %b exp 01", i, bus_a.yellow); end
         end
      end
   endtask

   // Random sensors: lamps at most one-hot and consistent with phase/active_dir.
   task automatic test_random_onehot();
      logic [1:0] ga, ya;
      logic [3:0] gb, yb;
      apply_reset(2'b00, 4'b0000);
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         ga = (bus_a.phase == 2'd0) ? (2'b01 << bus_a.active_dir) : 2'b00;
         ya = (bus_a.phase == 2'd1) ? (2'b01 << bus_a.active_dir) : 2'b00;
         gb = (bus_b.phase == 2'd0) ? (4'b0001 << bus_b.active_dir) : 4'b0000;
         yb = (bus_b.phase == 2'd1) ? (4'b0001 << bus_b.active_dir) : 4'b0000;
         n_checks++; if (!$onehot0(bus_a.green | bus_a.yellow) || (bus_a.green & bus_a.yellow) != 2'b00)
            begin n_fail++; $display("FAIL rand_onehot_a cyc %0d got g=%b y=%b exp at most one lamp", i, bus_a.green, bus_a.yellow); end
         n_checks++; if (!$onehot0(bus_b.green | bus_b.yellow) || (bus_b.green & bus_b.yellow) != 4'b0000)
            begin n_fail++; $display("FAIL rand_onehot_b cyc %0d got g=%b y=%b exp at most one lamp", i, bus_b.green, bus_b.yellow); end
         n_checks++; if (bus_a.phase === 2'd3 || bus_a.green !== ga || bus_a.yellow !== ya)
            begin n_fail++; $display("FAIL rand_lamps_a cyc %0d got g=%b y=%b exp g=%b y=%b", i, bus_a.green, bus_a.yellow, ga, ya); end
         n_checks++; if (bus_b.phase === 2'd3 || bus_b.green !== gb || bus_b.yellow !== yb)
            begin n_fail++; $display("FAIL rand_lamps_b cyc %0d got g=%b y=%b exp g=%b y=%b", i, bus_b.green, bus_b.yellow, gb, yb); end
         bus_a.car = 2'($urandom_range(0, 3));
         bus_b.car = 4'($urandom_range(0, 15));
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      bus_a.car = '0;
      bus_b.car = '0;
      test_reset();
      test_idle_hold();
      test_basic_change();
      test_wraparound();
      test_round_robin4();
      test_withdrawal();
      test_reset_mid_yellow();
      test_random_onehot();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_lite_rr.md
TRAFFIC_LITE_RR -- requirements
Module: traffic_lite_rr

Interface
REQ-001 Parameter NUM_DIR, default 2, meaning number of approaches (2..8).
REQ-002 Parameter MIN_GREEN, default 8, meaning minimum green cycles before a change is allowed (>=1).
REQ-003 Parameter MAX_GREEN, default 32, meaning green cycles after which a pending request forces a change (>=MIN_GREEN).
REQ-004 Parameter YELLOW_TIME, default 4, meaning yellow duration in cycles (>=1).
REQ-005 Parameter ALL_RED_TIME, default 2, meaning all-red clearance duration in cycles (>=1).
REQ-006 Parameter CNT_W, default 8, meaning phase counter width; SHALL hold MAX_GREEN.
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 car  input  NUM_DIR  per-approach car sensor, level, active-high, synchronous to clk.
REQ-010 green  output  NUM_DIR  one-hot green lamp, bit i = approach i.
REQ-011 yellow  output  NUM_DIR  one-hot yellow lamp, bit i = approach i.
REQ-012 active_dir  output  clog2(NUM_DIR) (min 1)  index of approach currently owning green/yellow.
REQ-013 phase  output  2  00 GREEN, 01 YELLOW, 10 ALL_RED; 11 unused.

Function
REQ-014 FSM states SHALL be GREEN, YELLOW, ALL_RED; all outputs SHALL be registered (no combinational car-to-lamp path).
REQ-015 A red lamp is implied for approach i whenever green[i] and yellow[i] are both 0; no red port.
REQ-016 Counter cnt SHALL reset to 0 on each state entry and increment by 1 per cycle, saturating at 2^CNT_W-1.
REQ-017 Request set = car with bit active_dir masked off.
REQ-018 In GREEN, transition to YELLOW SHALL occur when cnt >= MIN_GREEN-1 and request set is nonzero.
REQ-019 In GREEN with empty request set, controller SHALL hold green indefinitely (cnt saturates), regardless of car[active_dir].
REQ-020 MAX_GREEN: once cnt >= MAX_GREEN-1 with nonzero request, transition SHALL occur that cycle (covered by REQ-018; MAX_GREEN bounds no extension logic and is reported only for compatibility) -- green SHALL never exceed MAX_GREEN cycles while a request is pending.
REQ-021 Next direction SHALL be chosen round-robin: first requesting index scanning active_dir+1, +2, ... modulo NUM_DIR; latched into next_dir on the GREEN->YELLOW edge.
REQ-022 YELLOW SHALL last exactly YELLOW_TIME cycles, then ALL_RED.
REQ-023 ALL_RED SHALL last exactly ALL_RED_TIME cycles with green=0, yellow=0; then active_dir<=next_dir and enter GREEN.
REQ-024 Request withdrawal during YELLOW or ALL_RED SHALL NOT abort the change; latched next_dir is served.
REQ-025 Simultaneous requests: lowest round-robin distance wins; the active approach's own car bit is never a request.
REQ-026 At most one bit of green|yellow SHALL be set in any cycle; green and yellow SHALL never both be set.
REQ-027 Wrap-around: active_dir=NUM_DIR-1 with request on 0 SHALL select 0.

Reset
REQ-028 rst_n low SHALL immediately force state GREEN, active_dir=0, next_dir=0, cnt=0, green=1 (bit 0), yellow=0, phase=00.
REQ-029 Reset asserted mid-YELLOW or mid-ALL_RED SHALL abandon the pending change; after release, MIN_GREEN restarts from 0 on approach 0.
REQ-030 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Verification (defaults unless stated)
REQ-031 Reset, car=0 for 100 cycles -> green=01, yellow=00, phase=00 throughout.
REQ-032 car=10 held from reset release -> green[0] for 8 cycles, yellow[0] 4 cycles, all-off 2 cycles, then green=10, active_dir=1.
REQ-033 NUM_DIR=4, active_dir=1, car=1101 -> next approach 2, then 3, then 0 on successive rounds with car held.
REQ-034 car=10 pulsed for 1 cycle after cnt=10 in GREEN on 0 -> full yellow/all-red sequence, green moves to 1 even though car dropped.
REQ-035 rst_n pulsed low during YELLOW on approach 0 -> outputs asynchronously return to green=01, phase=00; next green change no earlier than 8 cycles after release.
REQ-036 Random car stimulus 10k cycles -> REQ-026 one-hot and never-both assertions hold every cycle.
